// File: rtl/la_ioring_seq.sv
// Power sequencer for a sectioned IO ring: ordered switch-on / de-isolate,
// reverse-order power-down, and a sticky all-off fault on pgood timeout or loss.
module la_ioring_seq #(
  parameter PROP = "DEFAULT",
  parameter int NSEC = 4,
  parameter int RINGW = 8,
  parameter int CNTW = 16,
  parameter int TIMEOUT = 1000,
  parameter int SETTLE = 16,
  localparam int IDXW = (NSEC > 1) ? $clog2(NSEC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_fault,
  input  logic [NSEC-1:0]  pgood,
  input  logic [RINGW-1:0] cfg,
  output logic [NSEC-1:0]  sw_en,
  output logic [NSEC-1:0]  iso,
  output logic [RINGW-1:0] ioring,
  output logic             ready,
  output logic             busy,
  output logic             fault,
  output logic [IDXW-1:0]  fault_idx
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    UP_WAIT   = 3'd1,
    UP_SETTLE = 3'd2,
    ON        = 3'd3,
    DN_ISO    = 3'd4,
    DN_WAIT   = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] ST_LAST  = CNTW'(SETTLE - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSEC - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_t state, state_next;
  logic [IDXW-1:0]  idx, idx_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [NSEC-1:0]  pgood_m, pgood_s;
  logic [NSEC-1:0]  sw_en_n, iso_n;
  logic [RINGW-1:0] ioring_n;
  logic             ready_n, busy_n, fault_n;
  logic [IDXW-1:0]  fault_idx_n;
  logic             loss;
  logic [IDXW-1:0]  loss_idx;

  // Alternative synchronizer cells for non-default PROP values slot in here.
  if (PROP == "DEFAULT") begin : g_sync_std
    always_ff @(posedge clk) begin
      if (reset) begin
        pgood_m <= {NSEC{1'b0}};
        pgood_s <= {NSEC{1'b0}};
      end else begin
        pgood_m <= pgood;
        pgood_s <= pgood_m;
      end
    end
  end else begin : g_sync_cell
    always_ff @(posedge clk) begin
      if (reset) begin
        pgood_m <= {NSEC{1'b0}};
        pgood_s <= {NSEC{1'b0}};
      end else begin
        pgood_m <= pgood;
        pgood_s <= pgood_m;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      idx       <= IDX_ZERO;
      cnt       <= CNT_ZERO;
      sw_en     <= {NSEC{1'b0}};
      iso       <= {NSEC{1'b1}};
      ioring    <= {RINGW{1'b0}};
      ready     <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      fault_idx <= IDX_ZERO;
    end else begin
      state     <= state_next;
      idx       <= idx_n;
      cnt       <= cnt_n;
      sw_en     <= sw_en_n;
      iso       <= iso_n;
      ioring    <= ioring_n;
      ready     <= ready_n;
      busy      <= busy_n;
      fault     <= fault_n;
      fault_idx <= fault_idx_n;
    end
  end

  // A section counts as already up below idx while powering up, and everywhere in ON.
  always_comb begin
    loss     = 1'b0;
    loss_idx = IDX_ZERO;
    for (int k = NSEC - 1; k >= 0; k--) begin
      if (!pgood_s[k] &&
          ((state == ON) ||
           (((state == UP_WAIT) || (state == UP_SETTLE)) && (IDXW'(k) < idx)))) begin
        loss     = 1'b1;
        loss_idx = IDXW'(k);
      end else begin
        loss     = loss;
        loss_idx = loss_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      OFF: begin
        if (en && !fault) state_next = UP_WAIT;
        else              state_next = OFF;
      end
      UP_WAIT: begin
        if (loss)                 state_next = FAULT;
        else if (!en)             state_next = DN_ISO;
        else if (pgood_s[idx])    state_next = UP_SETTLE;
        else if (cnt == TO_LAST)  state_next = FAULT;
        else                      state_next = UP_WAIT;
      end
      UP_SETTLE: begin
        if (loss)                 state_next = FAULT;
        else if (!en)             state_next = DN_ISO;
        else if (cnt == ST_LAST)  state_next = (idx == IDX_LAST) ? ON : UP_WAIT;
        else                      state_next = UP_SETTLE;
      end
      ON: begin
        if (loss)      state_next = FAULT;
        else if (!en)  state_next = DN_ISO;
        else           state_next = ON;
      end
      DN_ISO: state_next = DN_WAIT;
      DN_WAIT: begin
        if (cnt == ST_LAST) state_next = (idx == IDX_ZERO) ? OFF : DN_ISO;
        else                state_next = DN_WAIT;
      end
      FAULT: begin
        if (clr_fault && !en) state_next = OFF;
        else                  state_next = FAULT;
      end
      default: state_next = FAULT;
    endcase
  end

  // Next values of every registered output, derived from the current edge's transition.
  always_comb begin
    idx_n       = idx;
    cnt_n       = cnt;
    sw_en_n     = sw_en;
    iso_n       = iso;
    fault_n     = fault;
    fault_idx_n = fault_idx;
    case (state)
      OFF: begin
        idx_n = IDX_ZERO;
        cnt_n = CNT_ZERO;
        if (state_next == UP_WAIT) sw_en_n[0] = 1'b1;
        else                       sw_en_n    = sw_en;
      end
      UP_WAIT: begin
        if (state_next == UP_WAIT) cnt_n = cnt + CNT_ONE;
        else                       cnt_n = CNT_ZERO;
      end
      UP_SETTLE: begin
        if (state_next == UP_SETTLE) begin
          cnt_n = cnt + CNT_ONE;
        end else if ((state_next == UP_WAIT) || (state_next == ON)) begin
          iso_n[idx] = 1'b0;
          cnt_n      = CNT_ZERO;
          if (state_next == UP_WAIT) begin
            idx_n          = idx + IDXW'(1);
            sw_en_n[idx_n] = 1'b1;
          end else begin
            idx_n = idx;
          end
        end else begin
          cnt_n = CNT_ZERO;
        end
      end
      ON: begin
        if (state_next == DN_ISO) idx_n = IDX_LAST;
        else                      idx_n = idx;
      end
      DN_ISO: begin
        iso_n[idx] = 1'b1;
        cnt_n      = CNT_ZERO;
      end
      DN_WAIT: begin
        if (cnt == ST_LAST) begin
          sw_en_n[idx] = 1'b0;
          cnt_n        = CNT_ZERO;
          if (idx != IDX_ZERO) idx_n = idx - IDXW'(1);
          else                 idx_n = idx;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      FAULT: begin
        if (state_next == OFF) begin
          fault_n = 1'b0;
          idx_n   = IDX_ZERO;
          cnt_n   = CNT_ZERO;
        end else begin
          fault_n = 1'b1;
        end
      end
      default: begin
        idx_n = IDX_ZERO;
        cnt_n = CNT_ZERO;
      end
    endcase

    // Fault entry forces the ring safe on the very edge it is detected.
    if (state_next == FAULT) begin
      sw_en_n = {NSEC{1'b0}};
      iso_n   = {NSEC{1'b1}};
      cnt_n   = CNT_ZERO;
      fault_n = 1'b1;
      if (state != FAULT) fault_idx_n = loss ? loss_idx : idx;
      else                fault_idx_n = fault_idx;
    end else begin
      fault_idx_n = fault_idx;
    end

    ready_n  = (state_next == ON);
    busy_n   = (state_next == UP_WAIT) || (state_next == UP_SETTLE) ||
               (state_next == DN_ISO)  || (state_next == DN_WAIT);
    if ((state == ON) && (state_next == ON)) ioring_n = cfg;
    else                                     ioring_n = {RINGW{1'b0}};
  end

endmodule

// File: tb/tb_la_ioring_seq.sv
// Directed bench for la_ioring_seq with NSEC=2, TIMEOUT=8, SETTLE=4.
module tb_la_ioring_seq;
  logic       clk = 1'b0;
  logic       reset, en, clr_fault;
  logic [1:0] pgood;
  logic [7:0] cfg;
  logic [1:0] sw_en, iso;
  logic [7:0] ioring;
  logic       ready, busy, fault;
  logic       fault_idx;

  int errors = 0;
  int checks = 0;

  la_ioring_seq #(
    .PROP("DEFAULT"), .NSEC(2), .RINGW(8), .CNTW(16), .TIMEOUT(8), .SETTLE(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clr_fault(clr_fault), .pgood(pgood),
    .cfg(cfg), .sw_en(sw_en), .iso(iso), .ioring(ioring), .ready(ready),
    .busy(busy), .fault(fault), .fault_idx(fault_idx)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr_fault = 1'b0; pgood = 2'b11; cfg = 8'hA5;
    step(3);
    check("rst_sw_en", 32'(sw_en), 32'h0);
    check("rst_iso", 32'(iso), 32'h3);
    check("rst_ioring", 32'(ioring), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_idx", 32'(fault_idx), 32'h0);
    reset = 1'b0;
    step(3);

    // Power-up
    en = 1'b1;
    step(1);
    check("up_e1_sw_en", 32'(sw_en), 32'h1);
    check("up_e1_busy", 32'(busy), 32'h1);
    check("up_e1_iso", 32'(iso), 32'h3);
    step(4);
    check("up_e5_iso", 32'(iso), 32'h3);
    step(1);
    check("up_e6_iso", 32'(iso), 32'h2);
    check("up_e6_sw_en", 32'(sw_en), 32'h3);
    step(4);
    check("up_e10_ready", 32'(ready), 32'h0);
    step(1);
    check("up_e11_iso", 32'(iso), 32'h0);
    check("up_e11_ready", 32'(ready), 32'h1);
    check("up_e11_busy", 32'(busy), 32'h0);
    check("up_e11_ioring", 32'(ioring), 32'h0);
    step(1);
    check("up_e12_ioring", 32'(ioring), 32'hA5);
    cfg = 8'h3C;
    step(1);
    check("on_ioring_follow", 32'(ioring), 32'h3C);

    // Power-down from ON
    en = 1'b0;
    step(1);
    check("dn_e_ready", 32'(ready), 32'h0);
    check("dn_e_ioring", 32'(ioring), 32'h0);
    check("dn_e_busy", 32'(busy), 32'h1);
    step(1);
    check("dn_e1_iso", 32'(iso), 32'h2);
    step(3);
    check("dn_e4_sw_en", 32'(sw_en), 32'h3);
    step(1);
    check("dn_e5_sw_en", 32'(sw_en), 32'h1);
    step(1);
    check("dn_e6_iso", 32'(iso), 32'h3);
    step(3);
    check("dn_e9_sw_en", 32'(sw_en), 32'h1);
    step(1);
    check("dn_e10_sw_en", 32'(sw_en), 32'h0);
    check("dn_e10_busy", 32'(busy), 32'h0);

    // Timeout on section 0
    pgood = 2'b00;
    step(3);
    en = 1'b1;
    step(1);
    check("to_e1_sw_en", 32'(sw_en), 32'h1);
    step(6);
    check("to_e7_fault", 32'(fault), 32'h0);
    step(2);
    check("to_e9_fault", 32'(fault), 32'h1);
    check("to_fault_idx", 32'(fault_idx), 32'h0);
    check("to_sw_en", 32'(sw_en), 32'h0);
    check("to_busy", 32'(busy), 32'h0);
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("to_clr_en1_fault", 32'(fault), 32'h1);
    en = 1'b0; clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("to_clr_fault", 32'(fault), 32'h0);
    check("to_clr_busy", 32'(busy), 32'h0);
    pgood = 2'b11;
    step(3);

    // pgood loss in ON
    en = 1'b1;
    step(11);
    check("pl_ready", 32'(ready), 32'h1);
    step(1);
    pgood = 2'b01;
    step(3);
    check("pl_fault", 32'(fault), 32'h1);
    check("pl_fault_idx", 32'(fault_idx), 32'h1);
    check("pl_sw_en", 32'(sw_en), 32'h0);
    check("pl_iso", 32'(iso), 32'h3);
    check("pl_ioring", 32'(ioring), 32'h0);
    check("pl_ready0", 32'(ready), 32'h0);
    en = 1'b0; clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("pl_clr_fault", 32'(fault), 32'h0);
    step(2);

    // Abort during section-1 UP_WAIT (pgood[1] held low)
    en = 1'b1;
    step(6);
    check("ab_e6_sw_en", 32'(sw_en), 32'h3);
    check("ab_e6_iso", 32'(iso), 32'h2);
    step(2);
    en = 1'b0;
    step(1);
    check("ab_a_busy", 32'(busy), 32'h1);
    check("ab_a_iso", 32'(iso), 32'h2);
    step(4);
    check("ab_a4_sw_en", 32'(sw_en), 32'h3);
    step(1);
    check("ab_a5_sw_en", 32'(sw_en), 32'h1);
    step(1);
    check("ab_a6_iso", 32'(iso), 32'h3);
    step(4);
    check("ab_a10_sw_en", 32'(sw_en), 32'h0);
    check("ab_a10_busy", 32'(busy), 32'h0);
    check("ab_fault", 32'(fault), 32'h0);

    // Reset mid-sequence, then normal restart
    pgood = 2'b11;
    step(3);
    en = 1'b1;
    step(3);
    check("rm_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    step(1);
    check("rm_sw_en", 32'(sw_en), 32'h0);
    check("rm_iso", 32'(iso), 32'h3);
    check("rm_busy", 32'(busy), 32'h0);
    en = 1'b0;
    reset = 1'b0;
    step(3);
    en = 1'b1;
    step(1);
    check("rm_e1_sw_en", 32'(sw_en), 32'h1);
    step(10);
    check("rm_e11_ready", 32'(ready), 32'h1);
    check("rm_e11_iso", 32'(iso), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/la_ioring_seq.md
Name: la_ioring_seq

Overview:
- Power sequencer for an IO ring split into NSEC supply sections by IO-ring cut cells.
- Brings sections up in order 0..NSEC-1: switch enable, wait for power-good, settle, then release isolation.
- Brings sections down in reverse order. Drives the generic ioring control bus only while the whole ring is up.
- Faults to a safe all-off state on a power-good timeout or a power-good loss.

Parameters:
- PROP, "DEFAULT", cell property passthrough for implementation selection.
- NSEC, 4, number of ring sections (>=1).
- RINGW, 8, width of generic ioring control bus.
- CNTW, 16, width of the internal wait counter.
- TIMEOUT, 1000, max cycles to wait for pgood per section (1..2^CNTW-1).
- SETTLE, 16, settle cycles after pgood on power-up, and after iso on power-down (1..2^CNTW-1).
- IDXW, $clog2(NSEC) (min 1), section index width (localparam).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  level request: 1 = ring on, 0 = ring off.
- clr_fault  input  1  pulse; clears fault when en=0.
- pgood  input  NSEC  per-section power-good, asynchronous; double-flop synchronized internally.
- cfg  input  RINGW  ioring control value to drive when ring is up.
- sw_en  output  NSEC  per-section supply switch enable.
- iso  output  NSEC  per-section isolation, 1 = isolated.
- ioring  output  RINGW  registered ioring control bus.
- ready  output  1  all sections up and de-isolated.
- busy  output  1  sequencing in progress (UP_*/DN_*).
- fault  output  1  sticky fault flag.
- fault_idx  output  IDXW  section that caused the fault.

Behaviour:
- All outputs are registered.
- Reset values: sw_en=0, iso=all 1, ioring=0, ready=0, busy=0, fault=0, fault_idx=0, state=OFF, idx=0, cnt=0, synchronizer=0.
- pgood_s is pgood after 2 flops. All pgood checks below use pgood_s.
- OFF:
  - Outputs at safe values.
  - en=1 and fault=0 -> UP_WAIT with idx=0, cnt=0, sw_en[0]<=1.
- UP_WAIT:
  - pgood_s[idx]=1 -> UP_SETTLE, cnt=0.
  - Else if cnt==TIMEOUT-1 -> FAULT, fault_idx=idx. Otherwise cnt++.
- UP_SETTLE:
  - cnt++ each cycle. When cnt==SETTLE-1: iso[idx]<=0.
  - Then, if idx==NSEC-1 -> ON; else idx++, sw_en[idx+1]<=1, cnt=0 -> UP_WAIT.
- ON:
  - ready=1, busy=0. ioring<=cfg every cycle.
  - en=0 -> DN_ISO with idx=NSEC-1. ready<=0 and ioring<=0 on the same edge.
- DN_ISO:
  - iso[idx]<=1, cnt=0 -> DN_WAIT.
- DN_WAIT:
  - cnt++. When cnt==SETTLE-1: sw_en[idx]<=0.
  - Then, if idx==0 -> OFF; else idx-- -> DN_ISO.
- busy=1 in UP_WAIT, UP_SETTLE, DN_ISO, DN_WAIT.
- Abort on power-up: en=0 in UP_WAIT or UP_SETTLE -> DN_ISO with idx unchanged. The partially-up section is powered down, then idx-1..0.
- en re-asserted during DN_*: power-down completes to OFF. A new power-up starts from OFF if en is still 1.
- pgood loss: pgood_s[k]=0 for any already-up section k -> FAULT, fault_idx=k (lowest such k). Already-up means k<idx in UP_*, or any k in ON.
  - Simultaneous pgood loss and en=0: fault wins.
- FAULT:
  - On the next edge: sw_en=0, iso=all 1, ioring=0, ready=0, busy=0, fault=1.
  - Stays in FAULT until clr_fault=1 with en=0 -> OFF, fault<=0. clr_fault with en=1 is ignored.
- reset mid-sequence: immediate return to reset values; no ordered power-down.
- NSEC=1: idx is fixed at 0; the sequence is the same.

Test Plan (NSEC=2, TIMEOUT=8, SETTLE=4, pgood=2'b11 from reset, edge 1 = first edge sampling en=1):
- Power-up:
  - Edge 1: sw_en=01.
  - Edge 6: iso=10, sw_en=11.
  - Edge 11: iso=00, ready=1, busy=0.
  - Edge 12 onward: ioring=cfg (cfg=8'hA5 -> 8'hA5).
- Power-down from ON (en=0 at edge E):
  - Edge E: ready=0, ioring=0.
  - Edge E+1: iso=10.
  - Edge E+5: sw_en=01.
  - Edge E+6: iso=11.
  - Edge E+10: sw_en=00, state OFF.
- Timeout: pgood=00 -> after edge 8, fault=1, fault_idx=0, sw_en=00. clr_fault with en=1 leaves fault=1. en=0 + clr_fault -> fault=0, OFF.
- pgood loss: in ON, drop pgood[1] -> within 3 edges fault=1, fault_idx=1, sw_en=00, iso=11, ioring=0.
- Abort: drop en during section-1 UP_WAIT -> iso[1]=1, then sw_en[1]=0; iso[0]=1, then sw_en[0]=0; OFF, fault=0.
- Reset mid-sequence: reset=1 in UP_SETTLE -> after the next edge sw_en=00, iso=11, busy=0; restarts normally when reset=0.
